// File: rtl/ifetch_if.sv
// ----------------------------------------------------------------------------
// ifetch_if -- handshake bundle around the instruction-fetch stage.
//
// Signals
//   imem_req_valid/ready/addr : fetch request channel towards instruction memory
//   imem_rsp_valid/data       : in-order response channel from instruction memory
//   redirect_valid/pc         : branch/jump redirect from a later stage
//   out_valid/ready           : instruction handoff towards the id stage
//   out_instruction/out_pc    : instruction word and its address
//
// Modports
//   master : the fetch stage itself
//   slave  : its environment (memory, redirect source, id stage)
// ----------------------------------------------------------------------------
interface ifetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output out_valid, out_instruction, out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  out_valid, out_instruction, out_pc,
        output out_ready
    );
endinterface

// File: rtl/ifetch.sv
// ----------------------------------------------------------------------------
// ifetch -- instruction-fetch stage.
//
// Issues sequential word fetches to an in-order instruction memory, tags each
// response with the address it was fetched from, and buffers the results in a
// small FIFO that feeds the id stage. A redirect flushes the buffer, restarts
// fetching at the new target and drops the responses still in flight.
//
// Parameters
//   RESET_PC   : first fetch address after reset
//   FIFO_DEPTH : instruction-buffer entries (power of two, >= 2); also bounds
//                outstanding requests plus buffered instructions
//
// Ports
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ifetch_if.master (memory request/response, redirect, id handoff)
//   perf_fetch_cnt : instructions handed to id   (only with IFETCH_PERF_EN)
//   perf_flush_cnt : redirects taken             (only with IFETCH_PERF_EN)
//
// Optional feature macro: IFETCH_PERF_EN adds the two wrapping perf counters.
// ----------------------------------------------------------------------------
module ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    ifetch_if.master bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] buf_cnt;
    logic [PW-1:0] buf_rd;
    logic [PW-1:0] buf_wr;
    logic [PW-1:0] tag_rd;
    logic [PW-1:0] tag_wr;
    logic [31:0]   buf_data [FIFO_DEPTH];
    logic [31:0]   buf_pc   [FIFO_DEPTH];
    logic [31:0]   tag_q    [FIFO_DEPTH];

    logic          redirect;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic [CW:0]   occupancy;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] remaining;

    assign redirect  = bus.redirect_valid;
    assign occupancy = {1'b0, outstanding} + {1'b0, buf_cnt};

    // Requests are throttled so every accepted request is guaranteed a buffer
    // slot when it returns; this is what makes buffer overflow impossible.
    assign bus.imem_req_valid = (state == RUN) && !redirect && (occupancy < DEPTH_W);
    assign bus.imem_req_addr  = pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign push = (state == RUN) && bus.imem_rsp_valid && !redirect;
    assign pop  = bus.out_valid && bus.out_ready && !redirect;

    assign bus.out_valid       = (buf_cnt != '0);
    assign bus.out_instruction = bus.out_valid ? buf_data[buf_rd] : '0;
    assign bus.out_pc          = bus.out_valid ? buf_pc[buf_rd]   : '0;

    // Responses still owed by memory at a redirect. Only one of outstanding
    // and discard_cnt is non-zero at any time, depending on the state. A
    // response arriving in the redirect cycle itself is already accounted for.
    assign in_flight = (state == FLUSH) ? discard_cnt : outstanding;
    assign remaining = (bus.imem_rsp_valid && (in_flight != '0)) ? in_flight - CW'(1) : in_flight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= {RESET_PC[31:2], 2'b00};
            outstanding <= '0;
            discard_cnt <= '0;
            buf_cnt     <= '0;
            buf_rd      <= '0;
            buf_wr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
        end else if (redirect) begin
            pc          <= bus.redirect_pc & 32'hFFFF_FFFC;
            outstanding <= '0;
            discard_cnt <= remaining;
            buf_cnt     <= '0;
            buf_rd      <= '0;
            buf_wr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            state       <= (remaining != '0) ? FLUSH : RUN;
        end else begin
            case (state)
                IDLE: state <= RUN;
                RUN: begin
                    if (req_fire) begin
                        pc     <= pc + 32'd4;
                        tag_wr <= tag_wr + PW'(1);
                    end
                    if (bus.imem_rsp_valid) begin
                        tag_rd <= tag_rd + PW'(1);
                    end
                    outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
                end
                FLUSH: begin
                    if (bus.imem_rsp_valid && (discard_cnt != '0)) begin
                        discard_cnt <= discard_cnt - CW'(1);
                        if (discard_cnt == CW'(1)) begin
                            state <= RUN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (push) begin
                buf_wr <= buf_wr + PW'(1);
            end
            if (pop) begin
                buf_rd <= buf_rd + PW'(1);
            end
            buf_cnt <= buf_cnt + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: out_* are forced to zero while the buffer is empty.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_q[tag_wr] <= pc;
        end
        if (push) begin
            buf_data[buf_wr] <= bus.imem_rsp_data;
            buf_pc[buf_wr]   <= tag_q[tag_rd];
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(pop);
            perf_flush_cnt <= perf_flush_cnt + 32'(redirect);
        end
    end
`endif
endmodule

// File: tb/tb_ifetch.sv
// ----------------------------------------------------------------------------
// tb_ifetch -- self-checking bench for ifetch.
//
// A queue-based reference model (in-flight tag queue, instruction buffer
// queue, discard count) predicts every output each cycle. A behavioural
// memory answers accepted requests in order after a random latency. Directed
// segments pin the model with hand-computed values; random segments follow.
// A second instance with RESET_PC = 32'hFFFF_FFFC checks address wrap-around.
// ----------------------------------------------------------------------------
module tb_ifetch;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ifetch_if bus ();
    ifetch_if bus2 ();

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_flush;
    logic [31:0] perf2_fetch;
    logic [31:0] perf2_flush;
`endif

    ifetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch),
        .perf_flush_cnt (perf_flush)
`endif
    );

    ifetch #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf2_fetch),
        .perf_flush_cnt (perf2_flush)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    mreq_t       mem_q [$];
    ent_t        m_buf [$];
    logic [31:0] m_tags [$];
    int          m_discard;
    logic [31:0] m_pc;
    bit          m_first;
    logic [31:0] m_fetch;
    logic [31:0] m_flush;

    int          p_ready, p_rsp, p_outready, p_redirect, lat_max;
    bit          mem_hold;
    bit          force_redir;
    logic [31:0] force_pc;

    logic        obs_req_valid, obs_req_fire, obs_out_valid, obs_out_fire;
    logic [31:0] obs_req_addr, obs_out_pc, obs_out_ins;
    logic        obs2_valid;
    logic [31:0] obs2_addr;
    int          n_fire, n_pop;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_buf.delete();
        m_tags.delete();
        mem_q.delete();
        m_discard = 0;
        m_pc      = 32'h0000_0000;
        m_first   = 1'b1;
        m_fetch   = '0;
        m_flush   = '0;
        n_fire    = 0;
        n_pop     = 0;
    endtask

    task automatic apply_stimulus();
        bus.imem_req_ready = (int'($urandom % 100) < p_ready);
        bus.out_ready      = (int'($urandom % 100) < p_outready);
        if (!mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc && int'($urandom % 100) < p_rsp) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mem_q[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        if (force_redir) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = force_pc;
            force_redir        = 1'b0;
        end else if (int'($urandom % 100) < p_redirect) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = $urandom;
        end else begin
            bus.redirect_valid = 1'b0;
            bus.redirect_pc    = $urandom;
        end
    endtask

    task automatic check_output(input logic e_req);
        check_value("req_valid", 32'(bus.imem_req_valid), 32'(e_req));
        check_value("req_addr", bus.imem_req_addr, m_pc);
        check_value("out_valid", 32'(bus.out_valid), 32'(m_buf.size() > 0));
        check_value("out_pc", bus.out_pc, (m_buf.size() > 0) ? m_buf[0].pc : 32'h0);
        check_value("out_instruction", bus.out_instruction, (m_buf.size() > 0) ? m_buf[0].ins : 32'h0);
`ifdef IFETCH_PERF_EN
        check_value("perf_fetch", perf_fetch, m_fetch);
        check_value("perf_flush", perf_flush, m_flush);
`endif
    endtask

    task automatic run_cycle();
        logic        e_req, rv, rsp, ordy, rdy;
        logic [31:0] rpc, rdata;
        int          inflight;
        @(negedge clk);
        apply_stimulus();
        #1;
        e_req = !m_first && (m_discard == 0) && !bus.redirect_valid
                && (int'(m_tags.size() + m_buf.size()) < DEPTH);
        check_output(e_req);
        obs_req_valid = bus.imem_req_valid;
        obs_req_addr  = bus.imem_req_addr;
        obs_req_fire  = bus.imem_req_valid && bus.imem_req_ready;
        obs_out_valid = bus.out_valid;
        obs_out_fire  = bus.out_valid && bus.out_ready;
        obs_out_pc    = bus.out_pc;
        obs_out_ins   = bus.out_instruction;
        obs2_valid    = bus2.imem_req_valid;
        obs2_addr     = bus2.imem_req_addr;
        if (obs_req_fire) n_fire++;
        if (obs_out_fire && !bus.redirect_valid) n_pop++;
        rv    = bus.redirect_valid;
        rpc   = bus.redirect_pc;
        rsp   = bus.imem_rsp_valid;
        rdata = bus.imem_rsp_data;
        ordy  = bus.out_ready;
        rdy   = bus.imem_req_ready;
        @(posedge clk);
        if (rsp && mem_q.size() > 0) void'(mem_q.pop_front());
        if (obs_req_fire) mem_q.push_back('{addr: obs_req_addr, due: cyc + 1 + int'($urandom % lat_max)});
        if (rv) begin
            inflight  = m_tags.size() + m_discard;
            m_discard = (rsp && inflight > 0) ? inflight - 1 : inflight;
            m_tags.delete();
            m_buf.delete();
            m_pc    = rpc & 32'hFFFF_FFFC;
            m_first = 1'b0;
            m_flush = m_flush + 32'd1;
        end else if (m_first) begin
            m_first = 1'b0;
        end else begin
            if (m_buf.size() > 0 && ordy) begin
                void'(m_buf.pop_front());
                m_fetch = m_fetch + 32'd1;
            end
            if (rsp) begin
                if (m_discard > 0) m_discard--;
                else if (m_tags.size() > 0) m_buf.push_back('{pc: m_tags.pop_front(), ins: rdata});
            end
            if (e_req && rdy) begin
                m_tags.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
`ifdef IFETCH_PERF_EN
        check_value("perf_fetch_pre_reset", perf_fetch, m_fetch);
`endif
        #2 rst_n = 1'b0;
        #1;
        check_value("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_value("rst_req_addr", bus.imem_req_addr, 32'h0000_0000);
        check_value("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_value("rst_out_pc", bus.out_pc, 32'h0);
        check_value("rst_out_instruction", bus.out_instruction, 32'h0);
`ifdef IFETCH_PERF_EN
        check_value("rst_perf_fetch", perf_fetch, 32'h0);
        check_value("rst_perf_flush", perf_flush, 32'h0);
`endif
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] exp2_addr [4];
        logic        exp2_valid [4];
        int          seq_out, seq_req, fires0;
        bit          got, seen;

        exp2_addr  = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        exp2_valid = '{1'b0, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        bus2.imem_req_ready = 1'b1;
        bus2.imem_rsp_valid = 1'b0;
        bus2.imem_rsp_data  = '0;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        bus2.out_ready      = 1'b1;
        force_redir = 1'b0;
        force_pc    = '0;
        mem_hold    = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_value("init_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_value("init_req_addr", bus.imem_req_addr, 32'h0000_0000);
        check_value("init_out_valid", 32'(bus.out_valid), 32'd0);
        check_value("init_out_pc", bus.out_pc, 32'h0);
        check_value("init_out_instruction", bus.out_instruction, 32'h0);
        check_value("init2_req_addr", bus2.imem_req_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Zero-wait memory, id always ready: strictly sequential stream.
        p_ready = 100; p_rsp = 100; lat_max = 1; p_outready = 100; p_redirect = 0;
        seq_out = 0;
        seq_req = 0;
        for (int i = 0; i < 44; i++) begin
            if (i == 20) p_outready = 0;
            if (i == 30) begin
                check_value("stall_full_occupancy", 32'(n_fire - n_pop), 32'd2);
                p_outready = 100;
            end
            run_cycle();
            if (i < 4) begin
                check_value("wrap_req_valid", 32'(obs2_valid), 32'(exp2_valid[i]));
                check_value("wrap_req_addr", obs2_addr, exp2_addr[i]);
            end
            if (i >= 20 && i < 30) check_value("stall_bound", 32'(n_fire - n_pop <= 2), 32'd1);
            if (obs_req_fire) begin
                check_value("seq_req_addr", obs_req_addr, 32'(seq_req * 4));
                seq_req++;
            end
            if (obs_out_fire) begin
                check_value("seq_out_pc", obs_out_pc, 32'(seq_out * 4));
                check_value("seq_out_instruction", obs_out_ins, mem_word(32'(seq_out * 4)));
                seq_out++;
            end
        end
        check_value("seq_progress", 32'(seq_out >= 10), 32'd1);

        // Redirect with two responses in flight: both must be dropped.
        p_ready = 0;
        repeat (8) run_cycle();
        fires0   = n_fire;
        mem_hold = 1'b1;
        p_ready  = 100;
        for (int i = 0; i < 10 && (n_fire - fires0) < 2; i++) run_cycle();
        check_value("redir_two_inflight", 32'(n_fire - fires0), 32'd2);
        force_redir = 1'b1;
        force_pc    = 32'h0000_0103;
        run_cycle();
        check_value("redir_cycle_req_valid", 32'(obs_req_valid), 32'd0);
        run_cycle();
        check_value("flush_req_valid", 32'(obs_req_valid), 32'd0);
        check_value("flush_req_addr", obs_req_addr, 32'h0000_0100);
        mem_hold = 1'b0;
        got  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            run_cycle();
            if (obs_req_fire && !seen) begin
                check_value("redir_first_req", obs_req_addr, 32'h0000_0100);
                seen = 1'b1;
            end
            if (obs_out_fire) begin
                check_value("redir_first_out_pc", obs_out_pc, 32'h0000_0100);
                check_value("redir_first_out_ins", obs_out_ins, mem_word(32'h0000_0100));
                got = 1'b1;
            end
        end
        check_value("redir_out_seen", 32'(got), 32'd1);

        // Redirect colliding with a response while occupancy is at its limit.
        p_ready = 0;
        repeat (8) run_cycle();
        p_outready = 0;
        p_ready    = 100;
        fires0     = n_fire - n_pop;
        run_cycle();
        run_cycle();
        force_redir = 1'b1;
        force_pc    = 32'h0000_2000;
        run_cycle();
        check_value("collide_occupancy", 32'(n_fire - n_pop - fires0), 32'd2);
        check_value("collide_out_valid_before", 32'(obs_out_valid), 32'd1);
        run_cycle();
        check_value("collide_out_valid", 32'(obs_out_valid), 32'd0);
        check_value("collide_out_pc", obs_out_pc, 32'h0);
        check_value("collide_out_ins", obs_out_ins, 32'h0);
        check_value("collide_req_valid", 32'(obs_req_valid), 32'd1);
        check_value("collide_req_addr", obs_req_addr, 32'h0000_2000);

        // Randomized segments with occasional mid-stream resets.
        for (int s = 0; s < 40; s++) begin
            p_ready    = 30 + int'($urandom % 71);
            p_rsp      = 30 + int'($urandom % 71);
            lat_max    = 1 + int'($urandom % 4);
            p_outready = int'($urandom % 101);
            p_redirect = int'($urandom % 11);
            repeat (100) run_cycle();
            if (s % 8 == 7) do_reset();
        end

`ifdef IFETCH_PERF_EN
        check_value("perf2_fetch", perf2_fetch, 32'h0);
        check_value("perf2_flush", perf2_flush, 32'h0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 2, meaning instruction-buffer entries (power of two, >=2).
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 The module SHALL have port imem_req_ready  input  1  memory accepts a request this cycle.
REQ-007 The module SHALL have port imem_req_addr  output  32  fetch address, bits [1:0] always 0.
REQ-008 The module SHALL have port imem_rsp_valid  input  1  response valid; responses are in order, one per accepted request, latency >=1 cycle.
REQ-009 The module SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-010 The module SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-011 The module SHALL have port redirect_pc  input  32  redirect target.
REQ-012 The module SHALL have port out_valid  output  1  instruction presented to the id stage.
REQ-013 The module SHALL have port out_ready  input  1  id stage accepts this cycle.
REQ-014 The module SHALL have port out_instruction  output  32  instruction word to id (its input_instruction).
REQ-015 The module SHALL have port out_pc  output  32  address of out_instruction.

Function
REQ-016 The FSM SHALL have states IDLE (first cycle after reset release), RUN, and FLUSH; IDLE SHALL go to RUN unconditionally.
REQ-017 In RUN, imem_req_valid SHALL be 1 iff outstanding + buffer occupancy < FIFO_DEPTH and redirect_valid is 0.
REQ-018 On request acceptance (valid and ready), the PC SHALL advance by 4 with 32-bit wrap-around (32'hFFFF_FFFC -> 0), and the accepted address SHALL be queued for tagging its response.
REQ-019 A response in RUN SHALL be pushed into the buffer with its tagged PC; overflow SHALL be impossible by REQ-017.
REQ-020 The buffer head SHALL drive out_instruction/out_pc, with out_valid = not empty; both SHALL read 0 when empty.
REQ-021 A pop SHALL occur on out_valid and out_ready; push and pop in the same cycle SHALL leave occupancy unchanged, including when full.
REQ-022 Data SHALL have 1-cycle minimum latency from imem_rsp_valid to out_valid (registered buffer, no bypass).
REQ-023 redirect_valid SHALL take priority over every other event in its cycle: flush the buffer, drop any same-cycle response, set PC to {redirect_pc[31:2],2'b00}, suppress the request, and load discard_cnt with the outstanding count.
REQ-024 After a redirect, the FSM SHALL enter FLUSH if discard_cnt > 0, otherwise RUN.
REQ-025 In FLUSH, imem_req_valid SHALL be 0, each response SHALL decrement discard_cnt and be dropped, and the FSM SHALL return to RUN when discard_cnt reaches 0.
REQ-026 A new redirect during FLUSH SHALL update PC and keep discard_cnt counting the remaining in-flight responses.
REQ-027 While out_valid=1 and out_ready=0, out_instruction and out_pc SHALL hold stable.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately set FSM=IDLE, PC=RESET_PC, buffer empty, outstanding=0, discard_cnt=0, and imem_req_valid=0, out_valid=0, out_instruction=0, out_pc=0, imem_req_addr=RESET_PC.
REQ-029 Reset mid-transaction SHALL abandon all in-flight requests; the memory model SHALL be reset concurrently.

Configuration
REQ-030 With macro IFETCH_PERF_EN defined, the module SHALL add outputs perf_fetch_cnt (32, counts pops to id) and perf_flush_cnt (32, counts redirects), both reset to 0 and wrapping.
REQ-031 With IFETCH_PERF_EN undefined, those ports and counters SHALL be absent, with all other behaviour identical.

Verification
REQ-032 Zero-wait memory, out_ready=1, RESET_PC=0 -> addresses 0,4,8... issued; out_pc follows the same sequence with matching instruction words, none lost or duplicated.
REQ-033 out_ready=0 for 10 cycles -> at most 2 requests outstanding+buffered; out_instruction/out_pc stable; resumes in order after out_ready=1.
REQ-034 Redirect to 32'h0000_0103 with 2 responses in flight -> FSM=FLUSH, both responses dropped, next request addr 32'h0000_0100, first out_pc 32'h0000_0100.
REQ-035 Redirect and imem_rsp_valid in the same cycle with a full buffer -> buffer empty next cycle, response discarded, out_valid=0.
REQ-036 RESET_PC=32'hFFFF_FFFC -> requests 32'hFFFF_FFFC then 32'h0000_0000.
REQ-037 rst_n=0 asynchronously mid-stream -> all outputs reset within the same cycle; with IFETCH_PERF_EN, perf_fetch_cnt equals the handshake count before reset, then 0.
